eth_pkt_chk: RTL

Synthesizable GMII receive-side frame checker for the Ethernet test path. It sits on the PHY receive byte stream. It strips the preamble and SFD, runs the IEEE 802.3 CRC-32 over the frame, and checks the payload against the incrementing-byte test pattern (byte k = k mod 256). Checked payload is forwarded on a byte stream with SOF/EOF markers, and a per-frame status pulse and good/bad frame counters are produced.

---
 rtl/eth_pkt_chk.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_pkt_chk.sv
// GMII receive frame checker: strips preamble/SFD, checks CRC-32 and the
// incrementing-byte payload pattern, forwards payload and reports per-frame status.
module eth_pkt_chk #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter bit PAT_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_dat,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_dat,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_good,
  output logic        crc_err,
  output logic        len_err,
  output logic        pat_err,
  output logic        phy_err,
  output logic        sfd_err,
  output logic [15:0] frame_len,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  localparam logic [15:0] L_MIN   = 16'(MIN_LEN);
  localparam logic [15:0] L_MAX   = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  state_t      r_state, w_state_next;
  logic        r_dv_prev;
  logic [3:0]  r_pre_cnt;
  logic [31:0] r_crc;
  logic [15:0] r_byte_cnt;
  logic [39:0] r_dly;
  logic [2:0]  r_fill;
  logic [7:0]  r_pidx;
  logic        r_first, r_pat_sticky, r_phy_sticky;

  logic        w_rise, w_full, w_push, w_emit, w_end, w_drop_end;
  logic        w_crc_bad, w_len_bad, w_pat_bad, w_pat_fin, w_bad;
  logic [7:0]  w_oldest;
  logic [15:0] w_frame_len;
  logic [31:0] w_crc_next;

  // MSB-first register, data bits fed LSB first (802.3 bit order)
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] n;
    n = c;
    for (int i = 0; i < 8; i++) begin
      n = (n[31] ^ d[i]) ? ({n[30:0], 1'b0} ^ 32'h04C11DB7) : {n[30:0], 1'b0};
    end
    return n;
  endfunction

  assign w_rise      = rx_dv & ~r_dv_prev;
  assign w_full      = (r_fill == 3'd5);
  assign w_push      = (r_state == S_DATA) && rx_dv;
  assign w_end       = (r_state == S_DATA) && !rx_dv;
  assign w_emit      = (r_state == S_DATA) && w_full;
  assign w_drop_end  = (r_state == S_DROP) && !rx_dv;
  assign w_oldest    = r_dly[39:32];
  assign w_crc_next  = crc32_byte(r_crc, rx_dat);
  assign w_crc_bad   = (r_crc != RESIDUE);
  assign w_len_bad   = (r_byte_cnt < L_MIN) || (r_byte_cnt > L_MAX);
  assign w_pat_bad   = PAT_CHECK && (w_oldest != r_pidx);
  assign w_pat_fin   = r_pat_sticky | (w_full & w_pat_bad);
  assign w_bad       = w_crc_bad | w_len_bad | w_pat_fin | r_phy_sticky;
  assign w_frame_len = (r_byte_cnt > 16'd4) ? (r_byte_cnt - 16'd4) : 16'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_rise) w_state_next = (rx_dat == 8'h55) ? S_PRE : S_DROP;
      S_PRE: begin
        if (!rx_dv)                                   w_state_next = S_IDLE;
        else if (rx_er)                               w_state_next = S_DROP;
        else if (rx_dat == 8'hD5)                     w_state_next = S_DATA;
        else if (rx_dat == 8'h55 && r_pre_cnt != 4'hF) w_state_next = S_PRE;
        else                                          w_state_next = S_DROP;
      end
      S_DATA:  if (!rx_dv) w_state_next = S_IDLE;
      S_DROP:  if (!rx_dv) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  logic        w_valid_n, w_sof_n, w_eof_n, w_done_n, w_good_n;
  logic        w_crc_n, w_len_n, w_pat_n, w_phy_n, w_sfd_n;
  logic [7:0]  w_dat_n;
  logic [15:0] w_flen_n;

  always_comb begin
    w_valid_n = 1'b0;
    w_dat_n   = 8'h00;
    w_sof_n   = 1'b0;
    w_eof_n   = 1'b0;
    w_done_n  = 1'b0;
    w_good_n  = frame_good;
    w_crc_n   = crc_err;
    w_len_n   = len_err;
    w_pat_n   = pat_err;
    w_phy_n   = phy_err;
    w_sfd_n   = sfd_err;
    w_flen_n  = frame_len;
    if (w_emit) begin
      w_valid_n = 1'b1;
      w_dat_n   = w_oldest;
      w_sof_n   = r_first;
      w_eof_n   = w_end;
    end
    if (w_end) begin
      w_done_n = 1'b1;
      w_good_n = ~w_bad;
      w_crc_n  = w_crc_bad;
      w_len_n  = w_len_bad;
      w_pat_n  = w_pat_fin;
      w_phy_n  = r_phy_sticky;
      w_sfd_n  = 1'b0;
      w_flen_n = w_frame_len;
    end else if (w_drop_end) begin
      w_done_n = 1'b1;
      w_good_n = 1'b0;
      w_crc_n  = 1'b0;
      w_len_n  = 1'b0;
      w_pat_n  = 1'b0;
      w_phy_n  = 1'b0;
      w_sfd_n  = 1'b1;
      w_flen_n = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_dat    <= 8'h00;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      pat_err    <= 1'b0;
      phy_err    <= 1'b0;
      sfd_err    <= 1'b0;
      frame_len  <= 16'd0;
      good_cnt   <= 32'd0;
      bad_cnt    <= 32'd0;
    end else begin
      out_valid  <= w_valid_n;
      out_dat    <= w_dat_n;
      out_sof    <= w_sof_n;
      out_eof    <= w_eof_n;
      frame_done <= w_done_n;
      frame_good <= w_good_n;
      crc_err    <= w_crc_n;
      len_err    <= w_len_n;
      pat_err    <= w_pat_n;
      phy_err    <= w_phy_n;
      sfd_err    <= w_sfd_n;
      frame_len  <= w_flen_n;
      if (w_end && !w_bad)          good_cnt <= good_cnt + 32'd1;
      else if (w_end || w_drop_end) bad_cnt  <= bad_cnt + 32'd1;
    end
  end

  // r_dv_prev resets high so a frame already in flight at reset release is not joined
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dv_prev    <= 1'b1;
      r_pre_cnt    <= 4'd0;
      r_crc        <= 32'hFFFFFFFF;
      r_byte_cnt   <= 16'd0;
      r_dly        <= 40'd0;
      r_fill       <= 3'd0;
      r_pidx       <= 8'd0;
      r_first      <= 1'b1;
      r_pat_sticky <= 1'b0;
      r_phy_sticky <= 1'b0;
    end else begin
      r_dv_prev <= rx_dv;
      case (r_state)
        S_IDLE: if (w_rise) r_pre_cnt <= 4'd1;
        S_PRE: begin
          if (rx_dv && rx_dat == 8'h55) r_pre_cnt <= r_pre_cnt + 4'd1;
          if (rx_dv && !rx_er && rx_dat == 8'hD5) begin
            r_crc        <= 32'hFFFFFFFF;
            r_byte_cnt   <= 16'd0;
            r_fill       <= 3'd0;
            r_pidx       <= 8'd0;
            r_first      <= 1'b1;
            r_pat_sticky <= 1'b0;
            r_phy_sticky <= 1'b0;
          end
        end
        S_DATA: begin
          if (rx_dv) begin
            r_crc <= w_crc_next;
            if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
            r_dly <= {r_dly[31:0], rx_dat};
            if (!w_full) r_fill <= r_fill + 3'd1;
            if (w_full) begin
              r_pidx  <= r_pidx + 8'd1;
              r_first <= 1'b0;
              if (w_pat_bad) r_pat_sticky <= 1'b1;
            end
            if (rx_er) r_phy_sticky <= 1'b1;
          end else begin
            r_fill <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
